// File: rtl/stack_sequencer_if.sv
// Stack sequencer bus: control-unit strobes and captured operands in,
// data-memory stack port and PC/CCR reload out.
interface stack_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int PC_W   = 32,
    parameter int FLAG_W = 3
);
    logic              cs_call;
    logic              cs_ret;
    logic              cs_int;
    logic              cs_rti;
    logic [PC_W-1:0]   pc_ret;
    logic [PC_W-1:0]   pc_target;
    logic [FLAG_W-1:0] flags_in;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] sp;
    logic              pc_load;
    logic [PC_W-1:0]   pc_next;
    logic              flags_load;
    logic [FLAG_W-1:0] flags_out;
    logic              busy;
    logic              stall;

    // Control unit and data memory side
    modport master (
        output cs_call, cs_ret, cs_int, cs_rti,
        output pc_ret, pc_target, flags_in, mem_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, sp,
        input  pc_load, pc_next, flags_load, flags_out, busy, stall
    );

    // Sequencer side
    modport slave (
        input  cs_call, cs_ret, cs_int, cs_rti,
        input  pc_ret, pc_target, flags_in, mem_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, sp,
        output pc_load, pc_next, flags_load, flags_out, busy, stall
    );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle sequencer for CALL / RET / INT / RTI.
// Owns the full-descending stack pointer, issues one stack word access per
// cycle, and reloads PC and CCR at the end of each sequence. The front of
// the pipeline is stalled from the accept cycle until the return to IDLE.
module stack_sequencer #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter int                PC_W     = 32,
    parameter int                FLAG_W   = 3,
    parameter logic [ADDR_W-1:0] SP_RESET = '1,
    parameter logic [PC_W-1:0]   INT_VEC  = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    stack_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        POP_FL,
        POP_LO,
        POP_HI,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_CALL,
        OP_RET,
        OP_INT,
        OP_RTI
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0]   pc_ret_q, pc_ret_d;
    logic [PC_W-1:0]   pc_target_q, pc_target_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              any_strobe;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pc_load;
    logic [PC_W-1:0]   pc_next;
    logic              flags_load;
    logic [FLAG_W-1:0] flags_out;
    logic              busy;
    logic              stall;

    assign any_strobe = bus.cs_call | bus.cs_ret | bus.cs_int | bus.cs_rti;

    // Next state, stack pointer movement and operand capture
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sp_d        = sp_q;
        pc_ret_d    = pc_ret_q;
        pc_target_d = pc_target_q;
        flags_d     = flags_q;
        lo_d        = lo_q;

        case (state_q)
            IDLE: begin
                if (any_strobe) begin
                    pc_ret_d    = bus.pc_ret;
                    pc_target_d = bus.pc_target;
                    flags_d     = bus.flags_in;
                    if (bus.cs_int) begin
                        op_d    = OP_INT;
                        state_d = PUSH_HI;
                    end else if (bus.cs_rti) begin
                        op_d    = OP_RTI;
                        state_d = POP_FL;
                    end else if (bus.cs_ret) begin
                        op_d    = OP_RET;
                        state_d = POP_LO;
                    end else begin
                        op_d    = OP_CALL;
                        state_d = PUSH_HI;
                    end
                end
            end
            PUSH_HI: begin
                sp_d    = sp_q - ADDR_W'(1);
                state_d = PUSH_LO;
            end
            PUSH_LO: begin
                sp_d    = sp_q - ADDR_W'(1);
                state_d = (op_q == OP_INT) ? PUSH_FL : IDLE;
            end
            PUSH_FL: begin
                sp_d    = sp_q - ADDR_W'(1);
                state_d = IDLE;
            end
            POP_FL: begin
                sp_d    = sp_q + ADDR_W'(1);
                state_d = POP_LO;
            end
            POP_LO: begin
                sp_d = sp_q + ADDR_W'(1);
                if (op_q == OP_RTI) begin
                    flags_d = bus.mem_rdata[FLAG_W-1:0];
                end
                state_d = POP_HI;
            end
            POP_HI: begin
                sp_d    = sp_q + ADDR_W'(1);
                lo_d    = bus.mem_rdata;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_CALL;
            sp_q        <= SP_RESET;
            pc_ret_q    <= '0;
            pc_target_q <= '0;
            flags_q     <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            pc_ret_q    <= pc_ret_d;
            pc_target_q <= pc_target_d;
            flags_q     <= flags_d;
            lo_q        <= lo_d;
        end
    end

    // Memory and reload outputs decoded from state; reset silences them at once
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        pc_load    = 1'b0;
        pc_next    = '0;
        flags_load = 1'b0;
        flags_out  = '0;

        if (!rst) begin
            case (state_q)
                PUSH_HI: begin
                    mem_write = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = pc_ret_q[PC_W-1:DATA_W];
                end
                PUSH_LO: begin
                    mem_write = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = pc_ret_q[DATA_W-1:0];
                    if (op_q == OP_CALL) begin
                        pc_load = 1'b1;
                        pc_next = pc_target_q;
                    end
                end
                PUSH_FL: begin
                    mem_write = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, flags_q};
                    pc_load   = 1'b1;
                    pc_next   = INT_VEC;
                end
                POP_FL, POP_LO, POP_HI: begin
                    mem_read = 1'b1;
                    mem_addr = sp_q + ADDR_W'(1);
                end
                FIN: begin
                    pc_load = 1'b1;
                    pc_next = {bus.mem_rdata, lo_q};
                    if (op_q == OP_RTI) begin
                        flags_load = 1'b1;
                        flags_out  = flags_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy | ((state_q == IDLE) & any_strobe);

    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.sp         = sp_q;
    assign bus.pc_load    = pc_load;
    assign bus.pc_next    = pc_next;
    assign bus.flags_load = flags_load;
    assign bus.flags_out  = flags_out;
    assign bus.busy       = busy;
    assign bus.stall      = stall;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle sequencer for the stack-class instructions CALL, RET, INT and RTI in the five-stage pipeline.
- Accepts the decoded one-hot strobes from the control unit (cs_call, cs_ret, cs_int, cs_rti) and owns the stack pointer.
- Issues word-wide stack reads and writes to data memory, and drives the PC and flags reload.
- Holds the front of the pipeline stalled until the sequence completes.

Parameters:
- DATA_W, 16, data memory word width.
- ADDR_W, 12, data memory address width; also the SP width.
- PC_W, 32, program counter width; must equal 2*DATA_W.
- FLAG_W, 3, CCR width {C,N,Z}, carried in bits [FLAG_W-1:0] of a stack word.
- SP_RESET, 2^ADDR_W-1, SP value after reset.
- INT_VEC, 32'h0000_0010, PC loaded on INT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cs_call  in  1  CALL strobe from the control unit.
- cs_ret  in  1  RET strobe.
- cs_int  in  1  INT strobe.
- cs_rti  in  1  RTI strobe.
- pc_ret  in  PC_W  return address (PC+1 of the issuing instruction), sampled at accept.
- pc_target  in  PC_W  CALL target, sampled at accept.
- flags_in  in  FLAG_W  current CCR, sampled at accept.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_read.
- mem_read  out  1  stack read strobe.
- mem_write  out  1  stack write strobe.
- mem_addr  out  ADDR_W  stack access address.
- mem_wdata  out  DATA_W  stack write data.
- sp  out  ADDR_W  current stack pointer.
- pc_load  out  1  one-cycle PC reload strobe.
- pc_next  out  PC_W  PC value qualified by pc_load.
- flags_load  out  1  one-cycle CCR reload strobe.
- flags_out  out  FLAG_W  CCR value qualified by flags_load.
- busy  out  1  sequence in progress (state != IDLE).
- stall  out  1  stalls fetch/decode; equals busy OR (IDLE AND any strobe).

Behaviour:
- Reset: state=IDLE, sp=SP_RESET, capture registers cleared, all strobes and data outputs 0.
- rst mid-sequence aborts at once. No further mem access, and no pc_load or flags_load from the aborted sequence.
- Stack convention: full-descending.
  - Push: mem[sp]<=data, then sp<=sp-1.
  - Pop: addr=sp+1, then sp<=sp+1.
- SP arithmetic is mod 2^ADDR_W. Wraps silently, with no error flag.
- Accept happens only in IDLE.
  - Priority when several strobes are set: INT > RTI > RET > CALL.
  - On accept: latch op, pc_ret, pc_target and flags_in.
  - Strobes arriving while busy are ignored; the pipeline is stalled, so they must not occur.
- Outputs are decoded from state plus registers (Moore). mem_addr and mem_wdata are 0 when unused.
- States: IDLE, PUSH_HI, PUSH_LO, PUSH_FL, POP_FL, POP_LO, POP_HI, FIN.
- CALL (accept cycle t, back in IDLE at t+3; stall high t..t+2):
  - t+1 PUSH_HI: write pc_ret[31:16] at sp.
  - t+2 PUSH_LO: write pc_ret[15:0] at sp; pc_load=1, pc_next=pc_target.
- INT:
  - PUSH_HI and PUSH_LO as for CALL, with no pc_load in PUSH_LO.
  - t+3 PUSH_FL: write zero-extended flags at sp; pc_load=1, pc_next=INT_VEC. Back to IDLE at t+4.
- RET:
  - t+1 POP_LO: read sp+1.
  - t+2 POP_HI: read sp+1; capture lo=mem_rdata.
  - t+3 FIN: hi=mem_rdata; pc_load=1, pc_next={hi,lo}. Back to IDLE at t+4.
- RTI:
  - t+1 POP_FL: read.
  - t+2 POP_LO: read; capture flags=mem_rdata[FLAG_W-1:0].
  - t+3 POP_HI: read; capture lo.
  - t+4 FIN: capture hi; pc_load=1, flags_load=1. Back to IDLE at t+5.
- Net SP change: CALL -2, INT -3, RET +2, RTI +3.
- Back-to-back: a strobe present in the same cycle the sequencer returns to IDLE is accepted there. No bubble is required beyond the stall.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → sp=0xFFF; all strobes 0; stall=0.
- CALL with pc_ret=0x0001_0025, pc_target=0x0000_0200:
  - writes 0x0001@0xFFF, then 0x0025@0xFFE.
  - pc_load at t+2 with 0x0000_0200; sp=0xFFD; stall high 3 cycles.
- RET following that CALL, memory model echoing the writes:
  - reads at 0xFFE then 0xFFF.
  - pc_load at t+3 with 0x0001_0025; sp=0xFFF.
- INT with flags_in=3'b101, then RTI:
  - INT writes 3 words, flags word 0x0005@0xFFD; pc_next=0x0000_0010.
  - RTI restores flags_out=3'b101 and the PC; sp back to 0xFFF.
- Simultaneous cs_int and cs_call in IDLE: INT sequence runs (3 writes). CALL is dropped, with no second pc_load.
- rst asserted in PUSH_LO of a CALL: no pc_load that cycle or after; sp=0xFFF the next cycle; state IDLE.
- Wrap: force 2 pops from sp=0xFFF via RET → addresses 0x000 and 0x001; sp=0x001.
